// File: rtl/vasya_s27_pkg.sv
// Shared types, constants and the MISR step function for the s27 bank.
package vasya_s27_pkg;

  // Run controller states
  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_done = 2'd2
  } state_t;

  // Galois feedback taps of the 16-bit signature register
  localparam logic [15:0] MISR_POLY = 16'hB400;

  // One MISR compaction: shift right, fold in the feedback taps when the
  // bit shifted out was set, then xor in the parallel data word.
  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [15:0] din);
    logic [15:0] fb;
    fb = sig[0] ? MISR_POLY : 16'h0000;
    misr_step = (sig >> 1) ^ fb ^ din;
  endfunction

endpackage

// File: rtl/vasya_s27_core.sv
// One ISCAS-89 s27 channel: canonical gate network plus its three state flops.
module vasya_s27_core
  import vasya_s27_pkg::*;
(
  input  logic CK,
  input  logic RN,
  input  logic EN,
  input  logic G0,
  input  logic G1,
  input  logic G2,
  input  logic G3,
  output logic G17
);

  logic g5_reg, g6_reg, g7_reg;
  logic g5_next, g6_next, g7_next;
  logic g8, g9, g11, g12, g13, g14, g15, g16;

  // Canonical s27 gate network; G17 depends on inputs even while in reset
  always_comb begin
    g14     = ~G0;
    g8      = g14 & g6_reg;
    g12     = ~(G1 | g7_reg);
    g13     = ~(G2 | g12);
    g15     = g12 | g8;
    g16     = G3 | g8;
    g9      = ~(g16 & g15);
    g11     = ~(g5_reg | g9);
    g5_next = ~(g14 | g11);
    g6_next = g11;
    g7_next = g13;
    G17     = ~g11;
  end

  // State flops advance only on enabled edges, independent of the controller
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      g5_reg <= 1'b0;
      g6_reg <= 1'b0;
      g7_reg <= 1'b0;
    end else if (EN) begin
      g5_reg <= g5_next;
      g6_reg <= g6_next;
      g7_reg <= g7_next;
    end
  end

endmodule

// File: rtl/vasya_s27_bank.sv
// CH parallel s27 channels whose G17 outputs are compacted by a 16-bit MISR
// over a run window of LEN enabled cycles.
module vasya_s27_bank
  import vasya_s27_pkg::*;
#(
  parameter int               CH    = 4,
  parameter int               SIG_W = 16,
  parameter int               LEN   = 256,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             EN,
  input  logic             START,
  input  logic [CH-1:0]    G0,
  input  logic [CH-1:0]    G1,
  input  logic [CH-1:0]    G2,
  input  logic [CH-1:0]    G3,
  output logic [CH-1:0]    G17,
  output logic [SIG_W-1:0] SIG,
  output logic             BUSY,
  output logic             DONE
);

  // Wide enough to hold LEN itself; the run ends before it could wrap
  localparam int            CW    = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [SIG_W-1:0] sig_reg, sig_next;
  logic [SIG_W-1:0] g17_ext;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      vasya_s27_core u_core (
        .CK  (CK),
        .RN  (RN),
        .EN  (EN),
        .G0  (G0[gi]),
        .G1  (G1[gi]),
        .G2  (G2[gi]),
        .G3  (G3[gi]),
        .G17 (G17[gi])
      );
    end
  endgenerate

  // Zero-extend channel outputs to the MISR width (works for CH == SIG_W too)
  always_comb begin
    g17_ext          = '0;
    g17_ext[CH-1:0]  = G17;
  end

  // Controller next state, counter and signature; START edge only reloads
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sig_next   = sig_reg;
    case (state_reg)
      st_idle, st_done: begin
        if (START) begin
          state_next = st_run;
          cnt_next   = '0;
          sig_next   = SEED;
        end
      end
      st_run: begin
        if (EN) begin
          sig_next = misr_step(sig_reg, g17_ext);
          cnt_next = cnt_reg + 1'b1;
          if (cnt_next == LEN_C) begin
            state_next = st_done;
          end
        end
      end
      default: begin
        state_next = st_idle;
      end
    endcase
  end

  // Controller registers; reset drops any partial signature
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_reg <= st_idle;
      cnt_reg   <= '0;
      sig_reg   <= SEED;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sig_reg   <= sig_next;
    end
  end

  assign SIG  = sig_reg;
  assign BUSY = (state_reg == st_run);
  assign DONE = (state_reg == st_done);

endmodule

// File: tb/tb_vasya_s27_bank.sv
// Randomised scoreboard bench for vasya_s27_bank (CH=4, LEN=4).
module tb_vasya_s27_bank;

  localparam int          CH   = 4;
  localparam int          LEN  = 4;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic          EN = 1'b0;
  logic          START = 1'b0;
  logic [CH-1:0] G0 = '0, G1 = '0, G2 = '0, G3 = '0;
  logic [CH-1:0] G17;
  logic [15:0]   SIG;
  logic          BUSY, DONE;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m5 [CH];
  bit          m6 [CH];
  bit          m7 [CH];
  int          m_mode;   // 0 idle, 1 run, 2 done
  int          m_cnt;
  logic [15:0] m_sig;
  logic [15:0] exp_q [$];

  vasya_s27_bank #(.CH(CH), .SIG_W(16), .LEN(LEN), .SEED(SEED)) dut (
    .CK(CK), .RN(RN), .EN(EN), .START(START),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .G17(G17), .SIG(SIG), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [15:0] d);
    bit lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 16'hB400;
    return s ^ d;
  endfunction

  // s27 reduced to sum-of-products form
  function automatic void s27(input bit g0, g1, g2, g3, g5, g6, g7,
                              output bit g17, output bit n5, n6, n7);
    bit g8, g12, g11;
    g8  = !g0 && g6;
    g12 = !(g1 || g7);
    g11 = !g5 && (g3 || g8) && (g12 || g8);
    g17 = !g11;
    n5  = g0 && !g11;
    n6  = g11;
    n7  = !(g2 || g12);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m5[i] = 0; m6[i] = 0; m7[i] = 0;
    end
    m_mode = 0;
    m_cnt  = 0;
    m_sig  = SEED;
  endtask

  function automatic logic [CH-1:0] model_g17();
    logic [CH-1:0] v;
    bit o, a, b, c;
    for (int i = 0; i < CH; i++) begin
      s27(G0[i], G1[i], G2[i], G3[i], m5[i], m6[i], m7[i], o, a, b, c);
      v[i] = o;
    end
    return v;
  endfunction

  // One clock of stimulus, entered and left at a falling edge
  task automatic step(input bit en_i, input bit start_i,
                      input logic [CH-1:0] a0, a1, a2, a3);
    logic [CH-1:0] expg;
    bit o, n5, n6, n7;
    chk("busy", 32'(BUSY), 32'(m_mode == 1));
    chk("done", 32'(DONE), 32'(m_mode == 2));
    chk("sig", 32'(SIG), 32'(m_sig));
    EN = en_i; START = start_i;
    G0 = a0; G1 = a1; G2 = a2; G3 = a3;
    #1;
    expg = model_g17();
    chk("g17", 32'(G17), 32'(expg));
    if (en_i) begin
      for (int i = 0; i < CH; i++) begin
        s27(G0[i], G1[i], G2[i], G3[i], m5[i], m6[i], m7[i], o, n5, n6, n7);
        m5[i] = n5; m6[i] = n6; m7[i] = n7;
      end
    end
    if (m_mode == 1) begin
      if (en_i) begin
        m_sig = model_misr(m_sig, 16'(expg));
        m_cnt++;
        if (m_cnt == LEN) begin
          m_mode = 2;
          exp_q.push_back(m_sig);
        end
      end
    end else if (start_i) begin
      m_mode = 1;
      m_sig  = SEED;
      m_cnt  = 0;
    end
    @(negedge CK);
  endtask

  task automatic do_reset();
    RN = 1'b0;
    model_reset();
    #1;
    chk("rst_sig", 32'(SIG), 32'(SEED));
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_g17", 32'(G17), 32'(model_g17()));
    @(negedge CK);
    RN = 1'b1;
  endtask

  task automatic rnd_step(input bit en_i, input bit start_i);
    step(en_i, start_i, CH'($urandom()), CH'($urandom()), CH'($urandom()), CH'($urandom()));
  endtask

  // Monitor: a rising DONE presents a finished signature to the scoreboard
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(posedge CK);
      #2;
      if (DONE && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL run_sig: DONE rose with no run expected, SIG=%h", SIG);
        end else begin
          chk("run_sig", 32'(SIG), 32'(exp_q.pop_front()));
        end
      end
      prev_done = DONE;
    end
  end

  initial begin
    model_reset();
    @(negedge CK);
    // Reset with all inputs zero
    do_reset();
    chk("rst_g17_all_ones", 32'(G17), 32'hF);

    // Fixed pattern G0=1 G3=1 converges to G6=1, G17=0
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, '1, '0, '0, '1);
    chk("pattern_g17", 32'(G17), 32'h0);

    // Clean run with zero inputs: START then four enabled edges
    do_reset();
    step(1'b1, 1'b1, '0, '0, '0, '0);
    for (int k = 0; k < LEN; k++) step(1'b1, 1'b0, '0, '0, '0, '0);
    chk("zero_run_done", 32'(DONE), 32'd1);

    // EN toggling during a run
    step(1'b0, 1'b1, '0, '0, '0, '0);
    for (int k = 0; k < 2 * LEN; k++) rnd_step(k % 2 == 0, 1'b0);
    chk("toggle_run_done", 32'(DONE), 32'd1);

    // START mid-run ignored; START in DONE reloads
    step(1'b0, 1'b1, '0, '0, '0, '0);
    rnd_step(1'b1, 1'b0);
    rnd_step(1'b1, 1'b1);
    rnd_step(1'b1, 1'b0);
    rnd_step(1'b1, 1'b0);
    chk("midstart_done", 32'(DONE), 32'd1);
    rnd_step(1'b0, 1'b1);
    chk("restart_busy", 32'(BUSY), 32'd1);
    chk("restart_sig", 32'(SIG), 32'(SEED));

    // Reset in the middle of a run, then a full run
    rnd_step(1'b1, 1'b0);
    rnd_step(1'b1, 1'b0);
    do_reset();
    rnd_step(1'b1, 1'b1);
    for (int k = 0; k < LEN; k++) rnd_step(1'b1, 1'b0);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else rnd_step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    end

    // Drain and confirm every finished run was observed
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, '0, '0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
